// File: rtl/mill_pkg.sv
// Shared definitions for the Miller-coded frame deframer: FSM encoding,
// default frame size limit and the bit-clock length of one ETU.
package mill_pkg;

    localparam int MAX_BYTES_DEF = 64;
    localparam int ETU_CLKS      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } mill_state_e;

endpackage

// File: rtl/mill_byte_asm.sv
// Nine-bit LSB-first shift register with bit counter and odd-parity check.
// byte_o, parity_ok_o and nine_done_o describe the word as it will look after
// the current shift, so the caller can register the result on the same edge.
module mill_byte_asm (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic       data_i,
    output logic [7:0] byte_o,
    output logic       parity_ok_o,
    output logic       nine_done_o,
    output logic [3:0] bit_cnt_o,
    output logic [7:0] sr_hi_o
);

    logic [8:0] sr_q;
    logic [8:0] sr_nxt;
    logic [3:0] cnt_q;

    // Newest bit enters at the top, so after nine shifts the first bit sits in bit 0.
    assign sr_nxt      = {data_i, sr_q[8:1]};
    assign byte_o      = sr_nxt[7:0];
    assign parity_ok_o = ^sr_nxt;
    assign nine_done_o = shift_i && (cnt_q == 4'd8);
    assign bit_cnt_o   = cnt_q;
    assign sr_hi_o     = sr_q[8:1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= sr_nxt;
            cnt_q <= (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/mill_frame_deframer.sv
// Frame deframer behind the Miller decoder: finds SOF, assembles parity-checked
// bytes, classifies EOF as standard/short/bad and guards against overflow.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for SOF (modulated ETU carrying logic 0)
//   ST_DATA  | receiving 9-bit characters until an unmodulated ETU
//   ST_DRAIN | overflowed; swallowing bits until the frame goes idle
module mill_frame_deframer
    import mill_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic                             clk,
    input  logic                             in_enable,
    input  logic                             in_data,
    input  logic                             in_strobe,
    input  logic                             in_idle,
    output logic [7:0]                       out_byte,
    output logic                             out_byte_valid,
    output logic                             out_parity_err,
    output logic                             out_frame_end,
    output logic                             out_frame_ok,
    output logic                             out_short_frame,
    output logic [$clog2(MAX_BYTES+1)-1:0]   out_byte_count
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    mill_state_e   state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          bvalid_q, bvalid_d;
    logic          perr_q, perr_d;
    logic          fend_q, fend_d;
    logic          fok_q, fok_d;
    logic          short_q, short_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          asm_clear;
    logic          asm_shift;
    logic [7:0]    asm_byte;
    logic          asm_parity_ok;
    logic          asm_nine_done;
    logic [3:0]    asm_bit_cnt;
    logic [7:0]    asm_sr_hi;
    logic          last_bit;

    assign asm_clear = (state_q == ST_IDLE) && in_strobe && !in_idle && !in_data;
    assign asm_shift = (state_q == ST_DATA) && in_strobe && !in_idle;
    assign last_bit  = asm_sr_hi[7];

    mill_byte_asm u_byte_asm (
        .clk_i       (clk),
        .rst_n_i     (in_enable),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .data_i      (in_data),
        .byte_o      (asm_byte),
        .parity_ok_o (asm_parity_ok),
        .nine_done_o (asm_nine_done),
        .bit_cnt_o   (asm_bit_cnt),
        .sr_hi_o     (asm_sr_hi)
    );

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        bvalid_d = 1'b0;
        perr_d   = perr_q;
        fend_d   = 1'b0;
        fok_d    = fok_q;
        short_d  = short_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (asm_clear) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            ST_DATA: begin
                if (in_strobe && !in_idle) begin
                    if (asm_nine_done) begin
                        if (cnt_q == CW'(MAX_BYTES)) begin
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            byte_d   = asm_byte;
                            perr_d   = !asm_parity_ok;
                            bvalid_d = 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                            if (!asm_parity_ok) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end else if (in_strobe) begin
                    fend_d  = 1'b1;
                    state_d = ST_IDLE;
                    fok_d   = 1'b0;
                    short_d = 1'b0;
                    if (asm_bit_cnt == 4'd1 && !last_bit && cnt_q != '0) begin
                        fok_d = !err_q;
                    end else if (asm_bit_cnt == 4'd8 && !last_bit && cnt_q == '0) begin
                        // Seven data bits plus the trailing logic-0 end-of-frame bit.
                        fok_d    = 1'b1;
                        short_d  = 1'b1;
                        bvalid_d = 1'b1;
                        perr_d   = 1'b0;
                        byte_d   = {1'b0, asm_sr_hi[6:0]};
                    end
                end
            end

            ST_DRAIN: begin
                if (in_strobe && in_idle) begin
                    fend_d  = 1'b1;
                    fok_d   = 1'b0;
                    short_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge in_enable) begin
        if (!in_enable) begin
            state_q  <= ST_IDLE;
            byte_q   <= '0;
            bvalid_q <= 1'b0;
            perr_q   <= 1'b0;
            fend_q   <= 1'b0;
            fok_q    <= 1'b0;
            short_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            bvalid_q <= bvalid_d;
            perr_q   <= perr_d;
            fend_q   <= fend_d;
            fok_q    <= fok_d;
            short_q  <= short_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign out_byte        = byte_q;
    assign out_byte_valid  = bvalid_q;
    assign out_parity_err  = perr_q;
    assign out_frame_end   = fend_q;
    assign out_frame_ok    = fok_q;
    assign out_short_frame = short_q;
    assign out_byte_count  = cnt_q;

endmodule

// File: tb/tb_mill_frame_deframer.sv
// Directed bench for the Miller frame deframer: short, standard, parity-error,
// truncated, overflow and reset-abort frames against hand-computed results.
module tb_mill_frame_deframer;
    import mill_pkg::*;

    localparam int MAXB = 4;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          in_enable = 1'b0;
    logic          in_data = 1'b0;
    logic          in_strobe = 1'b0;
    logic          in_idle = 1'b0;
    logic [7:0]    out_byte;
    logic          out_byte_valid;
    logic          out_parity_err;
    logic          out_frame_end;
    logic          out_frame_ok;
    logic          out_short_frame;
    logic [CW-1:0] out_byte_count;

    mill_frame_deframer #(.MAX_BYTES(MAXB)) dut (
        .clk             (clk),
        .in_enable       (in_enable),
        .in_data         (in_data),
        .in_strobe       (in_strobe),
        .in_idle         (in_idle),
        .out_byte        (out_byte),
        .out_byte_valid  (out_byte_valid),
        .out_parity_err  (out_parity_err),
        .out_frame_end   (out_frame_end),
        .out_frame_ok    (out_frame_ok),
        .out_short_frame (out_short_frame),
        .out_byte_count  (out_byte_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: byte queue holds {parity_err, byte}; frame-end fields captured.
    logic [8:0] vq[$];
    int  n_fend   = 0;
    int  f_ok     = 0;
    int  f_short  = 0;
    int  f_cnt    = 0;
    int  f_withv  = 0;
    int  long_p   = 0;
    int  lat_bad  = 0;
    int  cyc      = 0;
    int  strobe_cyc = -10;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (in_strobe) strobe_cyc = cyc;
    end

    always @(negedge clk) begin
        if (out_byte_valid) begin
            vq.push_back({out_parity_err, out_byte});
            if (prev_v) long_p++;
            if (cyc != strobe_cyc) lat_bad++;
        end
        if (out_frame_end) begin
            n_fend++;
            f_ok    = int'(out_frame_ok);
            f_short = int'(out_short_frame);
            f_cnt   = int'(out_byte_count);
            f_withv = int'(out_byte_valid);
            if (prev_f) long_p++;
            if (cyc != strobe_cyc) lat_bad++;
        end
        prev_v = out_byte_valid;
        prev_f = out_frame_end;
    end

    task automatic send_bit(input logic d, input logic idl);
        repeat (ETU_CLKS - 1) @(posedge clk);
        #1;
        in_strobe = 1'b1;
        in_data   = d;
        in_idle   = idl;
        @(posedge clk);
        #1;
        in_strobe = 1'b0;
        in_idle   = 1'b0;
        in_data   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
    endtask

    task automatic end_frame(input logic last);
        send_bit(last, 1'b0);
        send_bit(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        vq.delete();
        n_fend  = 0;
        f_ok    = -1;
        f_short = -1;
        f_cnt   = -1;
        f_withv = -1;
    endtask

    task automatic send_reqa();
        logic [6:0] bits;
        bits = 7'h26;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(bits[i], 1'b0);
        end_frame(1'b0);
    endtask

    task automatic check_reqa(input string tag);
        chk({tag, "_nfend"}, n_fend, 1);
        chk({tag, "_nvalid"}, vq.size(), 1);
        if (vq.size() > 0) chk({tag, "_byte"}, int'(vq[0]), 32'h026);
        chk({tag, "_short"}, f_short, 1);
        chk({tag, "_ok"}, f_ok, 1);
        chk({tag, "_cnt"}, f_cnt, 0);
        chk({tag, "_withv"}, f_withv, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", int'({out_byte, out_byte_valid, out_parity_err, out_frame_end,
                             out_frame_ok, out_short_frame, out_byte_count}), 0);
        @(posedge clk);
        #1;
        in_enable = 1'b1;

        // Short frame, preceded by strobes that IDLE must ignore.
        clr();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_reqa();
        check_reqa("reqa");

        // Standard frame, good parity.
        clr();
        send_bit(1'b0, 1'b0);
        send_byte(8'h93, 1'b1);
        send_byte(8'h20, 1'b0);
        end_frame(1'b0);
        chk("std_nvalid", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("std_b0", int'(vq[0]), 32'h093);
            chk("std_b1", int'(vq[1]), 32'h020);
        end
        chk("std_nfend", n_fend, 1);
        chk("std_ok", f_ok, 1);
        chk("std_short", f_short, 0);
        chk("std_cnt", f_cnt, 2);
        chk("std_withv", f_withv, 0);

        // Parity error on the first byte.
        clr();
        send_bit(1'b0, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h20, 1'b0);
        end_frame(1'b0);
        chk("par_nvalid", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("par_b0", int'(vq[0]), 32'h193);
            chk("par_b1", int'(vq[1]), 32'h020);
        end
        chk("par_ok", f_ok, 0);
        chk("par_cnt", f_cnt, 2);

        // Truncated frame: five data bits then idle.
        clr();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        end_frame(1'b0);
        chk("trunc_nvalid", vq.size(), 0);
        chk("trunc_nfend", n_fend, 1);
        chk("trunc_ok", f_ok, 0);
        chk("trunc_short", f_short, 0);

        // Good byte but end-of-frame bit is 1.
        clr();
        send_bit(1'b0, 1'b0);
        send_byte(8'h5A, 1'b1);
        end_frame(1'b1);
        chk("eof1_nvalid", vq.size(), 1);
        chk("eof1_ok", f_ok, 0);
        chk("eof1_cnt", f_cnt, 1);

        // Overflow: five good bytes into a four-byte limit.
        clr();
        send_bit(1'b0, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        end_frame(1'b0);
        chk("ovf_nvalid", vq.size(), 4);
        if (vq.size() == 4) chk("ovf_b3", int'(vq[3]), 32'h044);
        chk("ovf_nfend", n_fend, 1);
        chk("ovf_ok", f_ok, 0);
        chk("ovf_short", f_short, 0);
        chk("ovf_cnt", f_cnt, 4);

        // Reset mid-frame after 12 bits, then a clean short frame.
        clr();
        send_bit(1'b0, 1'b0);
        send_byte(8'h81, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        in_enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_outs", int'({out_byte, out_byte_valid, out_parity_err, out_frame_end,
                               out_frame_ok, out_short_frame, out_byte_count}), 0);
        @(posedge clk);
        #1;
        in_enable = 1'b1;
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("abort_nfend", n_fend, 0);
        clr();
        send_reqa();
        check_reqa("post");

        chk("pulse_width", long_p, 0);
        chk("latency", lat_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
